read_fetch: RTL and testbench

Read-side counterpart of the accumulator write-back path. On a start pulse it fetches a burst of `ROWS` words from the on-chip buffer SRAM, beginning at a source address. It streams the words to the systolic-array input loader through a valid/ready interface, with a 2-entry skid buffer that absorbs the SRAM's 1-cycle read latency, then pulses a done flag. It sits between the buffer SRAM and the array feeder, driven by the top-level controller.

---
 rtl/tpu_pkg.sv | 12 +
 rtl/read_fetch_if.sv | 23 ++
 rtl/rd_skid_fifo.sv | 61 ++++++
 rtl/read_fetch.sv | 103 ++++++++++
 tb/tb_read_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared state encodings and default widths for the buffer read path
package tpu_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rf_state_e;
endpackage

// File: rtl/read_fetch_if.sv
// rtl/read_fetch_if.sv - SRAM read port plus valid/ready word stream of read_fetch
interface read_fetch_if import tpu_pkg::*; #(
  parameter int datawith = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
);
  logic                mem_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [datawith-1:0] mem_rdata;
  logic [datawith-1:0] data_out;
  logic                data_valid;
  logic                data_ready;
  logic                data_last;

  modport master (
    output mem_en, mem_addr, data_out, data_valid, data_last,
    input  mem_rdata, data_ready
  );

  modport slave (
    input  mem_en, mem_addr, data_out, data_valid, data_last,
    output mem_rdata, data_ready
  );
endinterface

// File: rtl/rd_skid_fifo.sv
// rtl/rd_skid_fifo.sv - 2-entry fall-through skid FIFO for SRAM read data
module rd_skid_fifo import tpu_pkg::*; #(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         head_valid,
  output logic [W-1:0] head_data
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         wr, rd;

  // An empty FIFO presents the arriving word directly; if it is taken at once it is never stored.
  always_comb begin
    wr       = push && !((count_q == 2'd0) && pop);
    rd       = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (rd) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({wr, rd})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0) || push;
  assign head_data  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : (push ? push_data : '0);
endmodule

// File: rtl/read_fetch.sv
// rtl/read_fetch.sv - burst read of ROWS words from buffer SRAM into the array feeder stream
module read_fetch import tpu_pkg::*; #(
  parameter int datawith = DEF_DATA_W,
  parameter int ROWS     = 8,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_start,
  input  logic [ADDR_W-1:0] addr_src,
  output logic              read_done,
  output logic              busy,
  read_fetch_if.master      bus
);
  localparam int               CNT_W    = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROWS - 1);

  rf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    pop_cnt_q, pop_cnt_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          fifo_count;
  logic                head_valid;
  logic [datawith-1:0] head_data;
  logic                pop;
  logic                issue;

  rd_skid_fifo #(.W(datawith)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_data  (bus.mem_rdata),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign pop = head_valid && bus.data_ready;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
    issue       = 1'b0;
    read_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_start) begin
          base_d      = addr_src;
          issue_cnt_d = '0;
          pop_cnt_d   = '0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Credit check: stored + in-flight words, less the one leaving now, must leave a free slot.
        issue = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        if (issue) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (pop_cnt_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        read_done = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus.mem_en     = issue;
  assign bus.mem_addr   = base_q + ADDR_W'(issue_cnt_q);
  assign bus.data_out   = head_data;
  assign bus.data_valid = head_valid;
  assign bus.data_last  = head_valid && (pop_cnt_q == LAST_IDX);
  assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_read_fetch.sv
// tb/tb_read_fetch.sv - randomized self-checking bench for read_fetch against a burst-level model
`timescale 1ns/1ps
module tb_read_fetch;
  import tpu_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int R8   = 8;
  localparam int MAXC = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start8 = 1'b0;
  logic          start1 = 1'b0;
  logic [AW-1:0] src8 = '0;
  logic [AW-1:0] src1 = '0;
  logic          done8, busy8, done1, busy1;

  int vectors = 0;
  int miscompares = 0;

  logic [30:0] tr_obs  [MAXC];
  logic [30:0] exp_obs [MAXC];
  logic        tr_rdy  [MAXC];
  int          ncyc;

  read_fetch_if #(.datawith(DW), .ADDR_W(AW)) b8 ();
  read_fetch_if #(.datawith(DW), .ADDR_W(AW)) b1 ();

  read_fetch #(.datawith(DW), .ROWS(R8), .ADDR_W(AW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .read_start(start8), .addr_src(src8),
    .read_done(done8), .busy(busy8), .bus(b8.master)
  );

  read_fetch #(.datawith(DW), .ROWS(1), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .read_start(start1), .addr_src(src1),
    .read_done(done1), .busy(busy1), .bus(b1.master)
  );

  always #5 clk = ~clk;

  // SRAM models: one-cycle read latency, word = address + 0x100
  always @(posedge clk) if (b8.mem_en) b8.mem_rdata <= DW'(b8.mem_addr) + 16'h100;
  always @(posedge clk) if (b1.mem_en) b1.mem_rdata <= DW'(b1.mem_addr) + 16'h100;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {en, addr, valid, data, last, done, busy}; addr/data zeroed when not qualified
  function automatic logic [30:0] pack(input logic en, input logic [AW-1:0] a, input logic v,
                                       input logic [DW-1:0] d, input logic l, input logic dn,
                                       input logic bz);
    return {en, en ? a : {AW{1'b0}}, v, v ? d : {DW{1'b0}}, l, dn, bz};
  endfunction

  // Runs one ROWS=8 burst, recording every cycle from 1 until two cycles after read_done.
  // mode: 0 ready held high, 1 pattern 1,0,0,1, 2 random
  task automatic run8(input logic [AW-1:0] base, input int mode, input int inj_cycle,
                      input logic [AW-1:0] inj_addr);
    int   after;
    logic rdy;
    after = -1;
    ncyc  = 0;
    @(negedge clk);
    start8 = 1'b1;
    src8   = base;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    src8   = AW'($urandom);
    for (int c = 1; c < MAXC; c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((c % 4) == 1) || ((c % 4) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      b8.data_ready = rdy;
      tr_rdy[c]     = rdy;
      if (c == inj_cycle) begin
        start8 = 1'b1;
        src8   = inj_addr;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      tr_obs[c] = pack(b8.mem_en, b8.mem_addr, b8.data_valid, b8.data_out, b8.data_last, done8, busy8);
      ncyc = c;
      if (after > 0) after--;
      if (done8 && after < 0) after = 2;
      if (after == 0) break;
      @(posedge clk);
      #1;
    end
    b8.data_ready = 1'b0;
    start8        = 1'b0;
  endtask

  // Burst-level reference: a word may issue while fewer than 2 are outstanding after this
  // cycle's acceptance; a word is presentable the cycle after it was issued.
  task automatic model8(input logic [AW-1:0] base);
    int            issued, acc, done_c;
    logic          v, pop, en;
    logic [AW-1:0] a, da;
    issued = 0;
    acc    = 0;
    done_c = -1;
    for (int c = 1; c <= ncyc; c++) begin
      v   = issued > acc;
      pop = v && tr_rdy[c];
      en  = (issued < R8) && ((issued - acc - int'(pop)) < 2);
      a   = base + AW'(issued);
      da  = base + AW'(acc);
      exp_obs[c] = pack(en, a, v, DW'(da) + 16'h100, v && (acc == R8 - 1), c == done_c,
                        (done_c < 0) || (c <= done_c));
      if (pop && acc == R8 - 1) done_c = c + 1;
      issued += int'(en);
      acc    += int'(pop);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b8.data_ready = 1'b0;
    b1.data_ready = 1'b0;
    #1;
    vectors++;
    if ({b8.mem_en, b8.mem_addr, b8.data_out, b8.data_valid, b8.data_last, done8, busy8} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut8: outputs %h, expected all zero",
               {b8.mem_en, b8.mem_addr, b8.data_out, b8.data_valid, b8.data_last, done8, busy8});
    end
    vectors++;
    if ({b1.mem_en, b1.mem_addr, b1.data_out, b1.data_valid, b1.data_last, done1, busy1} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut1: outputs %h, expected all zero",
               {b1.mem_en, b1.mem_addr, b1.data_out, b1.data_valid, b1.data_last, done1, busy1});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run8(10'h010, 0, 0, '0);
    model8(10'h010);
    for (int c = 1; c <= ncyc; c++) begin
      vectors++;
      if (tr_obs[c] !== exp_obs[c]) begin
        miscompares++;
        $display("FAIL basic cycle %0d: got %h expected %h", c, tr_obs[c], exp_obs[c]);
      end
    end
    for (int c = 2; c <= 9; c++) begin
      vectors++;
      if (tr_obs[c][19:3] !== {1'b1, 16'h110 + 16'(c - 2)}) begin
        miscompares++;
        $display("FAIL basic_word cycle %0d: got %h expected %h", c, tr_obs[c][18:3], 16'h110 + 16'(c - 2));
      end
    end
    for (int c = 1; c <= ncyc; c++) begin
      vectors++;
      if ({tr_obs[c][2], tr_obs[c][1]} !== {c == 9, c == 10}) begin
        miscompares++;
        $display("FAIL basic_last_done cycle %0d: got %b expected %b", c,
                 {tr_obs[c][2], tr_obs[c][1]}, {c == 9, c == 10});
      end
    end
  endtask

  task automatic test_ready_toggle();
    int iss, acc;
    run8(AW'($urandom), 1, 0, '0);
    model8(tr_obs[1][29:20]);
    iss = 0;
    acc = 0;
    for (int c = 1; c <= ncyc; c++) begin
      vectors++;
      if (tr_obs[c] !== exp_obs[c]) begin
        miscompares++;
        $display("FAIL toggle cycle %0d: got %h expected %h", c, tr_obs[c], exp_obs[c]);
      end
      vectors++;
      if (iss - acc > 2) begin
        miscompares++;
        $display("FAIL toggle_outstanding cycle %0d: got %0d expected <= 2", c, iss - acc);
      end
      iss += int'(tr_obs[c][30]);
      acc += int'(tr_obs[c][19] && tr_rdy[c]);
    end
    vectors++;
    if (acc !== R8 || iss !== R8) begin
      miscompares++;
      $display("FAIL toggle_count: accepted %0d issued %0d expected %0d", acc, iss, R8);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want;
    int            k;
    run8(10'd1022, 0, 0, '0);
    model8(10'd1022);
    k = 0;
    for (int c = 1; c <= ncyc; c++) begin
      vectors++;
      if (tr_obs[c] !== exp_obs[c]) begin
        miscompares++;
        $display("FAIL wrap cycle %0d: got %h expected %h", c, tr_obs[c], exp_obs[c]);
      end
      if (tr_obs[c][30]) begin
        want = (k < 2) ? AW'(1022 + k) : AW'(k - 2);
        vectors++;
        if (tr_obs[c][29:20] !== want) begin
          miscompares++;
          $display("FAIL wrap_addr issue %0d: got %0d expected %0d", k, tr_obs[c][29:20], want);
        end
        k++;
      end
    end
  endtask

  task automatic test_start_ignored();
    run8(10'h123, 0, 3, 10'h3F0);
    model8(10'h123);
    for (int c = 1; c <= ncyc; c++) begin
      vectors++;
      if (tr_obs[c] !== exp_obs[c]) begin
        miscompares++;
        $display("FAIL start_ignored cycle %0d: got %h expected %h", c, tr_obs[c], exp_obs[c]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [AW-1:0] nb;
    @(negedge clk);
    start8 = 1'b1;
    src8   = 10'h040;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    b8.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({b8.mem_en, b8.mem_addr, b8.data_out, b8.data_valid, b8.data_last, done8, busy8} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h expected all zero",
               {b8.mem_en, b8.mem_addr, b8.data_out, b8.data_valid, b8.data_last, done8, busy8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({done8, b8.data_valid, busy8} !== 3'b000) begin
        miscompares++;
        $display("FAIL mid_reset_quiet %0d: done/valid/busy %b expected 000", c, {done8, b8.data_valid, busy8});
      end
    end
    b8.data_ready = 1'b0;
    nb = AW'($urandom);
    run8(nb, 2, 0, '0);
    model8(nb);
    for (int c = 1; c <= ncyc; c++) begin
      vectors++;
      if (tr_obs[c] !== exp_obs[c]) begin
        miscompares++;
        $display("FAIL after_reset cycle %0d: got %h expected %h", c, tr_obs[c], exp_obs[c]);
      end
    end
  endtask

  task automatic test_rows1();
    logic [30:0] obs, ex;
    @(negedge clk);
    start1 = 1'b1;
    src1   = 10'h2A5;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      b1.data_ready = (c >= 6);
      @(negedge clk);
      obs = pack(b1.mem_en, b1.mem_addr, b1.data_valid, b1.data_out, b1.data_last, done1, busy1);
      ex  = pack(c == 1, 10'h2A5, (c >= 2) && (c <= 6), 16'h3A5, (c >= 2) && (c <= 6), c == 7, c <= 7);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL rows1 cycle %0d: got %h expected %h", c, obs, ex);
      end
      @(posedge clk);
      #1;
    end
    b1.data_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] nb;
    int            inj;
    for (int n = 0; n < 6; n++) begin
      nb  = AW'($urandom);
      inj = $urandom_range(0, 6);
      run8(nb, 2, inj, AW'($urandom));
      model8(nb);
      for (int c = 1; c <= ncyc; c++) begin
        vectors++;
        if (tr_obs[c] !== exp_obs[c]) begin
          miscompares++;
          $display("FAIL random burst %0d cycle %0d: got %h expected %h", n, c, tr_obs[c], exp_obs[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_wrap();
    test_start_ignored();
    test_reset_mid_burst();
    test_rows1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
